// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared 16x16 signed multiplier with timeout and round-robin grant.
// Define MULT_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] res_out,
    output logic        res_id,
    output logic        res_valid,
    output logic        err,
    output logic        busy,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_ready,
    input  logic [31:0] mul_result
);

    localparam logic [5:0] CntLast = 6'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        id_q, id_d;
    logic        err_q, err_d;
    logic        win;

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign win = ~req0;
`else
    // last_q holds the requester served most recently; reset value lets requester 0 win first.
    logic last_q, last_d;
    assign win = (req0 & req1) ? ~last_q : req1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        id_d    = id_q;
        err_d   = err_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    gnt_d   = win;
                    opa_d   = win ? a1 : a0;
                    opb_d   = win ? b1 : b0;
                    cnt_d   = 6'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 6'd1;
                // The first two RUN cycles may still see ready from the previous job.
                if (cnt_q >= 6'd2 && mul_ready) begin
                    res_d   = mul_result;
                    err_d   = 1'b0;
                    id_d    = gnt_q;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    res_d   = 32'd0;
                    err_d   = 1'b1;
                    id_d    = gnt_q;
                    state_d = StDone;
                end
            end
            StDone: begin
`ifndef MULT_ARB_FIXED_PRIO_EN
                last_d  = gnt_q;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            gnt_q   <= 1'b0;
            opa_q   <= 16'd0;
            opb_q   <= 16'd0;
            res_q   <= 32'd0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            id_q    <= id_d;
            err_q   <= err_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign mul_start = (state_q == StRun);
    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StDone);
    assign ack0      = res_valid & ~gnt_q;
    assign ack1      = res_valid & gnt_q;
    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    assign res_out   = res_q;
    assign res_id    = id_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed/randomized bench for mult_arbiter with a behavioural multiplier and reference model.
module tb_mult_arbiter;

    localparam int T = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, res_id, res_valid, err, busy, mul_start;
    logic [31:0] res_out;
    logic [15:0] mul_a, mul_b;
    logic        mul_ready;
    logic [31:0] mul_result;

    int          mcnt = 0;
    bit          tie0 = 1'b0;
    bit          stale = 1'b0;
    logic [31:0] stale_val = 32'hdeadbeef;
    bit          last_srv = 1'b1;
    logic [31:0] last_res = 32'd0;
    logic        last_err = 1'b0;
    logic        last_id = 1'b0;
    int          n_vec = 0;
    int          n_fail = 0;

    mult_arbiter #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .res_out   (res_out),
        .res_id    (res_id),
        .res_valid (res_valid),
        .err       (err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] prod(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] sx, sy;
        sx = {{16{x[15]}}, x};
        sy = {{16{y[15]}}, y};
        return sx * sy;
    endfunction

    // Multiplier model: ready 18 cycles after start rises; optional stale ready at job start.
    always @(posedge clk) mcnt <= mul_start ? mcnt + 1 : 0;
    assign mul_ready  = !tie0 && ((mcnt >= 18) || (stale && mcnt < 2));
    assign mul_result = (mcnt >= 18) ? prod(mul_a, mul_b) : stale_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~last_srv;
`endif
        end
        return r1;
    endfunction

    task automatic reset_check(input string tag);
        check({tag, " ack0"}, ack0, 0);
        check({tag, " ack1"}, ack1, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_out"}, res_out, 0);
        check({tag, " res_id"}, res_id, 0);
        check({tag, " err"}, err, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " mul_start"}, mul_start, 0);
        check({tag, " mul_a"}, mul_a, 0);
        check({tag, " mul_b"}, mul_b, 0);
    endtask

    // Expects a grant at the base-th edge from now; returns in the DONE cycle.
    task automatic serve(input string tag, input int base, input bit scramble);
        bit          w, seen;
        logic [15:0] ea, eb;
        logic [31:0] er;
        int          exp_edges, lat;
        w         = pick(req0, req1);
        ea        = w ? a1 : a0;
        eb        = w ? b1 : b0;
        er        = tie0 ? 32'd0 : prod(ea, eb);
        exp_edges = base + (tie0 ? T : 19);
        lat       = 0;
        seen      = 1'b0;
        while (!seen && lat < exp_edges + 10) begin
            @(posedge clk);
            lat++;
            #1;
            if (scramble && lat == base) begin
                req0 = 1'b0;
                req1 = 1'b0;
                a0 = 16'($urandom); b0 = 16'($urandom);
                a1 = 16'($urandom); b1 = 16'($urandom);
            end
            seen = res_valid;
        end
        check({tag, " res_valid"}, seen, 1);
        check({tag, " latency"}, lat, exp_edges);
        check({tag, " ack0"}, ack0, !w);
        check({tag, " ack1"}, ack1, w);
        check({tag, " res_id"}, res_id, w);
        check({tag, " res_out"}, res_out, er);
        check({tag, " err"}, err, tie0);
        check({tag, " busy"}, busy, 1);
        check({tag, " mul_start"}, mul_start, 0);
        check({tag, " mul_a"}, mul_a, ea);
        check({tag, " mul_b"}, mul_b, eb);
        last_srv = w;
        last_res = er;
        last_err = tie0;
        last_id  = w;
    endtask

    // One cycle with no requests: outputs idle and the last result held.
    task automatic idle_gap(input string tag);
        @(posedge clk);
        #1;
        check({tag, " gap res_valid"}, res_valid, 0);
        check({tag, " gap acks"}, {ack1, ack0}, 0);
        check({tag, " gap busy"}, busy, 0);
        check({tag, " gap res_out"}, res_out, last_res);
        check({tag, " gap err"}, err, last_err);
        check({tag, " gap res_id"}, res_id, last_id);
    endtask

    initial begin
        int n_ack;
        int who;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");
        rst_n = 1'b1;

        // Simultaneous requests straight out of reset, then the loser back-to-back.
        a0 = 16'd100; b0 = 16'd200; a1 = 16'h8000; b1 = 16'h8000;
        req0 = 1'b1; req1 = 1'b1;
        serve("dual_first", 1, 0);
        check("dual_first value", res_out, 32'd20000);
        req0 = 1'b0;
        serve("dual_second", 2, 0);
        check("dual_second value", res_out, 32'h4000_0000);
        req1 = 1'b0;
        idle_gap("dual");

        a0 = 16'd3; b0 = 16'hfff9;
        req0 = 1'b1;
        serve("basic", 1, 0);
        check("basic value", res_out, 32'hffff_ffeb);
        req0 = 1'b0;
        idle_gap("basic");

        // Both held across four jobs.
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) serve("held", (i == 0) ? 1 : 2, 0);
        req0 = 1'b0; req1 = 1'b0;
        idle_gap("held");

        // Single random requests; odd jobs drop req and change operands after the grant.
        for (int i = 0; i < 4; i++) begin
            who = int'($urandom_range(0, 1));
            a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            req0 = (who == 0); req1 = (who == 1);
            serve("single", 1, (i % 2) == 1);
            req0 = 1'b0; req1 = 1'b0;
            idle_gap("single");
        end

        tie0 = 1'b1;
        a1 = 16'($urandom); b1 = 16'($urandom);
        req1 = 1'b1;
        serve("timeout", 1, 0);
        req1 = 1'b0;
        tie0 = 1'b0;
        idle_gap("timeout");

        a0 = 16'($urandom); b0 = 16'($urandom);
        req0 = 1'b1;
        serve("prestale", 1, 0);
        stale_val = last_res;
        stale = 1'b1;
        req0 = 1'b0;
        a1 = 16'($urandom); b1 = 16'($urandom) | 16'd1;
        req1 = 1'b1;
        serve("stale", 2, 0);
        stale = 1'b0;
        req1 = 1'b0;
        idle_gap("stale");

        a0 = 16'($urandom); b0 = 16'($urandom);
        req0 = 1'b1;
        serve("prereset", 1, 0);
        req0 = 1'b0;
        idle_gap("prereset");

        // Reset while RUN counter is 8.
        a0 = 16'($urandom); b0 = 16'($urandom);
        req0 = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        reset_check("midrun");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_srv = 1'b1; last_res = 32'd0; last_err = 1'b0; last_id = 1'b0;
        n_ack = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1) n_ack++;
        end
        check("midrun no_ack", n_ack, 0);
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        serve("after_reset", 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        idle_gap("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
